minmax_pipe: RTL
================

Name: minmax_pipe

Overview:
Pipelined, parametrised min/max reduction tree over NUM_CHUNKS packed chunks of CHUNK_SIZE bits. Produces min, max, their chunk indices and the range (max - min) for the flit compressor's base/delta selection. Has one register stage per tree level and a valid/ready handshake on both sides. The signed/unsigned compare mode is selected per transaction.

Parameters:
NUM_CHUNKS, 16, number of chunks in the input word; power of 2, at least 2
CHUNK_SIZE, 8, bits per chunk
IDX_BITS, $clog2(NUM_CHUNKS), width of the index outputs (derived; do not override)
LEVELS, $clog2(NUM_CHUNKS), number of tree levels, equal to the pipeline depth (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  pipeline can accept the word this cycle
in_data  in  NUM_CHUNKS*CHUNK_SIZE  packed chunks; chunk k = in_data[k*CHUNK_SIZE +: CHUNK_SIZE]
in_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled together with in_data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
min_data  out  CHUNK_SIZE  minimum chunk value
max_data  out  CHUNK_SIZE  maximum chunk value
min_idx  out  IDX_BITS  index of the minimum chunk
max_idx  out  IDX_BITS  index of the maximum chunk
range_data  out  CHUNK_SIZE  max_data - min_data, unsigned, modulo 2^CHUNK_SIZE
out_signed  out  1  in_signed carried with the word

Behaviour:
- One clock, synchronous active-high reset.
- Reset clears all stage valid bits and out_valid to 0. It also clears min_data, max_data, min_idx, max_idx, range_data and out_signed to 0. In-flight words are discarded.
- While rst is high, in_ready = 0.
- Global stall: advance = !(out_valid && !out_ready), and in_ready = advance. When advance = 0, every stage register holds its value, including the valid bits.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage 1 registers level-1 pair results. Each later stage reduces pairs from the previous stage. Stage LEVELS drives the outputs directly from registers.
- range_data is computed in the final stage from the final min/max and registered with them.
- Latency is LEVELS cycles from the input transfer to out_valid with no stall; 16 chunks gives 4 cycles.
- Throughput is one word per cycle while out_ready = 1.
- Bubbles propagate as valid = 0 and do not block advance. Data registers of invalid stages may load don't-care values.
- Each node compares (value, index) pairs, separately for min and max.
  - Signed mode uses $signed compare; unsigned mode uses plain compare.
  - Tie-break: when values are equal, the lower index wins for both min and max. Each node therefore passes its left operand (lower index range) on a tie.
- The in_signed bit travels with its word through every stage, so mixed modes in consecutive words are correct.
- range_data is the plain subtraction max - min in CHUNK_SIZE bits. In signed mode it is the true difference, interpreted as unsigned; it always fits because max >= min.
- When all chunks are equal: min_idx = max_idx = 0 and range_data = 0.
- Reset asserted mid-stream: on the next edge all valid bits are 0, and no stale output appears after reset is released.
- A simultaneous input transfer and output transfer in the same cycle is legal and expected.

Decomposition:
- Package minmax_pkg holds:
  - the node result struct {value [CHUNK_SIZE-1:0], idx [IDX_BITS-1:0]}, parametrised via localparams or a typedef in the instantiating scope;
  - the helper function cmp_lt(a, b, signed_mode).
- Sub-module minmax_node is purely combinational. Inputs: two min pairs, two max pairs and signed_mode. Outputs: the winning min pair and the winning max pair.
- minmax_pipe instantiates NUM_CHUNKS-1 minmax_node instances through generate loops over levels, with pipeline registers between levels. There are no hand-unrolled levels.

Test Plan:
- Unsigned, distinct values, NUM_CHUNKS=16, CHUNK_SIZE=8. Chunk k = 0x10+k, except chunk 5 = 0x03 and chunk 11 = 0xF0 -> after 4 cycles: min_data=0x03, min_idx=5, max_data=0xF0, max_idx=11, range_data=0xED.
- Signed vs unsigned on the same data. Chunk 0 = 0x80, chunk 1 = 0x7F, all others 0x00. With in_signed=0 -> min=0x00 idx 2, max=0x80 idx 0, range=0x80. With in_signed=1 -> min=0x80 idx 0, max=0x7F idx 1, range=0xFF.
- Ties: all chunks 0x42 -> min_idx=0, max_idx=0, range=0. Chunks 3 and 9 both 0xFF, others 0x01 -> max_idx=3, min_idx=0.
- Back-to-back stream plus backpressure. Send 8 consecutive words and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid && !out_ready. No word is lost or duplicated, order is preserved, and each result matches the scoreboard.
- Reset mid-operation: assert rst for 1 cycle with 3 words in flight -> out_valid=0 and all outputs 0 the next cycle, and no result from those words ever appears. A word sent after reset is released returns with 4-cycle latency.
- Parameter sweep over NUM_CHUNKS=2 with CHUNK_SIZE=16, and NUM_CHUNKS=32 with CHUNK_SIZE=4, using random data -> latency equals LEVELS and results match a reference model in both signed and unsigned modes.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared compare helper for the min/max reduction pipeline.
// The node result struct is declared in minmax_pipe, because its field widths follow that module's parameters.
package minmax_pkg;

    // Operands are widened to this width before comparing, so one helper serves every chunk size.
    localparam int CMP_W = 64;

    function automatic logic cmp_lt(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             signed_mode
    );
        logic lt;
        if (signed_mode) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
        return lt;
    endfunction

endpackage

// File: rtl/minmax_node.sv
// One combinational tree node: picks the smaller min pair and the larger max pair.
// On equal values the a-side (lower index range) is kept.
module minmax_node
    import minmax_pkg::*;
#(
    parameter int CHUNK_SIZE = 8,
    parameter int IDX_BITS   = 4
) (
    input  logic [CHUNK_SIZE-1:0] min_a_value,
    input  logic [IDX_BITS-1:0]   min_a_idx,
    input  logic [CHUNK_SIZE-1:0] min_b_value,
    input  logic [IDX_BITS-1:0]   min_b_idx,
    input  logic [CHUNK_SIZE-1:0] max_a_value,
    input  logic [IDX_BITS-1:0]   max_a_idx,
    input  logic [CHUNK_SIZE-1:0] max_b_value,
    input  logic [IDX_BITS-1:0]   max_b_idx,
    input  logic                  signed_mode,
    output logic [CHUNK_SIZE-1:0] min_value,
    output logic [IDX_BITS-1:0]   min_idx,
    output logic [CHUNK_SIZE-1:0] max_value,
    output logic [IDX_BITS-1:0]   max_idx
);

    function automatic logic [CMP_W-1:0] widen(input logic [CHUNK_SIZE-1:0] v, input logic s);
        return {{(CMP_W-CHUNK_SIZE){s & v[CHUNK_SIZE-1]}}, v};
    endfunction

    logic take_min_b;
    logic take_max_b;

    always_comb begin
        // Strict compares so that a tie never selects the b-side.
        take_min_b = cmp_lt(widen(min_b_value, signed_mode), widen(min_a_value, signed_mode), signed_mode);
        take_max_b = cmp_lt(widen(max_a_value, signed_mode), widen(max_b_value, signed_mode), signed_mode);
        min_value  = take_min_b ? min_b_value : min_a_value;
        min_idx    = take_min_b ? min_b_idx   : min_a_idx;
        max_value  = take_max_b ? max_b_value : max_a_value;
        max_idx    = take_max_b ? max_b_idx   : max_a_idx;
    end

endmodule

// File: rtl/minmax_pipe.sv
// Pipelined min/max reduction tree with one register stage per tree level and a
// global-stall valid/ready handshake; the signed/unsigned mode travels with each word.
module minmax_pipe
    import minmax_pkg::*;
#(
    parameter int NUM_CHUNKS = 16,
    parameter int CHUNK_SIZE = 8,
    parameter int IDX_BITS   = $clog2(NUM_CHUNKS),
    parameter int LEVELS     = $clog2(NUM_CHUNKS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CHUNKS*CHUNK_SIZE-1:0] in_data,
    input  logic                             in_signed,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHUNK_SIZE-1:0]            min_data,
    output logic [CHUNK_SIZE-1:0]            max_data,
    output logic [IDX_BITS-1:0]              min_idx,
    output logic [IDX_BITS-1:0]              max_idx,
    output logic [CHUNK_SIZE-1:0]            range_data,
    output logic                             out_signed
);

    typedef struct packed {
        logic [CHUNK_SIZE-1:0] value;
        logic [IDX_BITS-1:0]   idx;
    } node_t;

    // Handshake: a word enters on in_valid && in_ready and leaves on out_valid && out_ready.
    // The whole pipe stalls only while a valid result is refused; bubbles never block.
    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance && !rst;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_OUT = NUM_CHUNKS >> (l + 1);

        node_t                 src_min  [2*N_OUT];
        node_t                 src_max  [2*N_OUT];
        logic                  src_valid;
        logic                  src_signed;
        logic [CHUNK_SIZE-1:0] nmin_val [N_OUT];
        logic [IDX_BITS-1:0]   nmin_idx [N_OUT];
        logic [CHUNK_SIZE-1:0] nmax_val [N_OUT];
        logic [IDX_BITS-1:0]   nmax_idx [N_OUT];
        node_t                 min_d    [N_OUT];
        node_t                 min_q    [N_OUT];
        node_t                 max_d    [N_OUT];
        node_t                 max_q    [N_OUT];
        logic                  valid_d;
        logic                  valid_q;
        logic                  signed_d;
        logic                  signed_q;

        if (l == 0) begin : g_src
            // Leaves: every chunk starts as both a min and a max candidate tagged with its index.
            for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
                assign src_min[k] = '{value: in_data[k*CHUNK_SIZE +: CHUNK_SIZE], idx: IDX_BITS'(k)};
                assign src_max[k] = src_min[k];
            end
            assign src_valid  = in_valid;
            assign src_signed = in_signed;
        end else begin : g_src
            for (genvar k = 0; k < 2*N_OUT; k++) begin : g_prev
                assign src_min[k] = g_lvl[l-1].min_q[k];
                assign src_max[k] = g_lvl[l-1].max_q[k];
            end
            assign src_valid  = g_lvl[l-1].valid_q;
            assign src_signed = g_lvl[l-1].signed_q;
        end

        for (genvar k = 0; k < N_OUT; k++) begin : g_node
            minmax_node #(
                .CHUNK_SIZE (CHUNK_SIZE),
                .IDX_BITS   (IDX_BITS)
            ) u_node (
                .min_a_value (src_min[2*k].value),
                .min_a_idx   (src_min[2*k].idx),
                .min_b_value (src_min[2*k+1].value),
                .min_b_idx   (src_min[2*k+1].idx),
                .max_a_value (src_max[2*k].value),
                .max_a_idx   (src_max[2*k].idx),
                .max_b_value (src_max[2*k+1].value),
                .max_b_idx   (src_max[2*k+1].idx),
                .signed_mode (src_signed),
                .min_value   (nmin_val[k]),
                .min_idx     (nmin_idx[k]),
                .max_value   (nmax_val[k]),
                .max_idx     (nmax_idx[k])
            );
        end

        always_comb begin
            valid_d  = valid_q;
            signed_d = signed_q;
            for (int k = 0; k < N_OUT; k++) begin
                min_d[k] = min_q[k];
                max_d[k] = max_q[k];
            end
            if (advance) begin
                valid_d  = src_valid;
                signed_d = src_signed;
                for (int k = 0; k < N_OUT; k++) begin
                    min_d[k] = '{value: nmin_val[k], idx: nmin_idx[k]};
                    max_d[k] = '{value: nmax_val[k], idx: nmax_idx[k]};
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q  <= 1'b0;
                signed_q <= 1'b0;
                for (int k = 0; k < N_OUT; k++) begin
                    min_q[k] <= '0;
                    max_q[k] <= '0;
                end
            end else begin
                valid_q  <= valid_d;
                signed_q <= signed_d;
                for (int k = 0; k < N_OUT; k++) begin
                    min_q[k] <= min_d[k];
                    max_q[k] <= max_d[k];
                end
            end
        end

        if (l == LEVELS - 1) begin : g_range
            // Modulo subtraction; in signed mode max >= min, so the true difference always fits.
            logic [CHUNK_SIZE-1:0] range_d;
            logic [CHUNK_SIZE-1:0] range_q;

            always_comb begin
                range_d = range_q;
                if (advance) begin
                    range_d = nmax_val[0] - nmin_val[0];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    range_q <= '0;
                end else begin
                    range_q <= range_d;
                end
            end
        end
    end

    assign out_valid  = g_lvl[LEVELS-1].valid_q;
    assign out_signed = g_lvl[LEVELS-1].signed_q;
    assign min_data   = g_lvl[LEVELS-1].min_q[0].value;
    assign min_idx    = g_lvl[LEVELS-1].min_q[0].idx;
    assign max_data   = g_lvl[LEVELS-1].max_q[0].value;
    assign max_idx    = g_lvl[LEVELS-1].max_q[0].idx;
    assign range_data = g_lvl[LEVELS-1].g_range.range_q;

endmodule
